// File: rtl/tdes_iter_core.sv
// -----------------------------------------------------------------------------
// tdes_iter_core
// Iterative DES / 3DES (EDE) block cipher core, encrypt and decrypt.
// ROUNDS_PER_CYCLE Feistel rounds are chained combinationally per clock; a
// pass takes 16/ROUNDS_PER_CYCLE cycles and 3DES runs three passes back to back
// without extra cycles at the pass boundaries.
//
// Ports
//   clock      system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   din/keys/controls valid       in_ready   core can accept a block
//   din        plaintext or ciphertext        key1..3    DES keys (parity ignored)
//   decrypt    0 = encrypt, 1 = decrypt       tdes       0 = DES(key1), 1 = 3DES EDE
//   out_valid  dout holds a result            out_ready  consumer takes dout
//   dout       result block                   busy       accept .. result taken
// -----------------------------------------------------------------------------
module tdes_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TDES_EN          = 1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] din,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  input  logic        decrypt,
  input  logic        tdes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dout,
  output logic        busy
);

  if (!(ROUNDS_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [4:0] RPC      = 5'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] LAST_RND = 4'(16 - ROUNDS_PER_CYCLE);

  // DES tables, 1-based bit positions with bit 1 = MSB.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
    28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53,
    46,42,50,36,29,32};
  // S-boxes: entry (row*16 + col) is the nibble at position 0 = leftmost.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[6'(k)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[6'(k)])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[6'(k)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[6'(k)])];
    return y;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
    e = e ^ k;
    for (int i = 0; i < 8; i++) begin
      six = e[6'(42 - 6 * i) +: 6];
      // Row is the outer bit pair, column the middle four bits.
      s[5'(28 - 4 * i) +: 4] =
        SBOX[3'(i)][8'(252 - 4 * int'({six[5], six[0], six[4:1]})) +: 4];
    end
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  // 3DES decrypt walks the keys in reverse order (key3, key2, key1).
  function automatic logic [63:0] pass_key(input logic [1:0] p, input logic rev,
                                           input logic [63:0] a, b, c);
    logic [1:0] q;
    q = rev ? 2'd2 - p : p;
    case (q)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] l_q, r_q, l_n, r_n;
  logic [27:0] c_q, d_q, c_n, d_n;
  logic [63:0] k1_q, k2_q, k3_q, dout_q;
  logic        dec_q, tdes_q;
  logic [3:0]  rnd_q;
  logic [1:0]  pass_q;
  logic        accept, last_cyc, last_pass, pass_dir, tdes_in;

  assign tdes_in   = (TDES_EN != 0) && tdes;
  assign accept    = in_valid && in_ready;
  assign last_cyc  = (rnd_q == LAST_RND);
  assign last_pass = (pass_q == (tdes_q ? 2'd2 : 2'd0));
  assign pass_dir  = dec_q ^ (pass_q == 2'd1);  // EDE: middle pass is inverted
  assign dout      = dout_q;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (last_cyc && last_pass) state_d = DONE;
      DONE:    if (accept) state_d = ROUND;
               else if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  // ROUNDS_PER_CYCLE Feistel steps with the matching key-schedule rotations.
  always_comb begin
    logic [4:0]  rnum;
    logic [31:0] tmp;
    logic        one;
    // NOTE: blocking assignments here chain each round into the next within the cycle.
    l_n = l_q; r_n = r_q; c_n = c_q; d_n = d_q;
    rnum = '0; tmp = '0; one = 1'b0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnum = 5'(rnd_q) + 5'(j) + 5'd1;
      one  = (rnum == 5'd1) || (rnum == 5'd2) || (rnum == 5'd9) || (rnum == 5'd16);
      if (!pass_dir) begin
        c_n = one ? {c_n[26:0], c_n[27]} : {c_n[25:0], c_n[27:26]};
        d_n = one ? {d_n[26:0], d_n[27]} : {d_n[25:0], d_n[27:26]};
      end else if (rnum != 5'd1) begin
        c_n = one ? {c_n[0], c_n[27:1]} : {c_n[1:0], c_n[27:2]};
        d_n = one ? {d_n[0], d_n[27:1]} : {d_n[1:0], d_n[27:2]};
      end
      tmp = r_n;
      r_n = l_n ^ f_func(r_n, perm_pc2({c_n, d_n}));
      l_n = tmp;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    // NOTE: every register is cleared by reset so an aborted block leaves no trace.
    if (rst) begin
      l_q <= '0; r_q <= '0; c_q <= '0; d_q <= '0;
      k1_q <= '0; k2_q <= '0; k3_q <= '0; dout_q <= '0;
      dec_q <= 1'b0; tdes_q <= 1'b0; rnd_q <= '0; pass_q <= '0;
    end else if (accept) begin
      {l_q, r_q} <= perm_ip(din);
      {c_q, d_q} <= perm_pc1(pass_key(2'd0, tdes_in && decrypt, key1, key2, key3));
      k1_q <= key1; k2_q <= key2; k3_q <= key3;
      dec_q <= decrypt; tdes_q <= tdes_in; rnd_q <= '0; pass_q <= '0;
    end else if (state_q == ROUND) begin
      rnd_q <= 4'(5'(rnd_q) + RPC);  // wraps to 0 at each pass boundary
      if (!last_cyc) begin
        l_q <= l_n; r_q <= r_n; c_q <= c_n; d_q <= d_n;
      end else if (last_pass) begin
        dout_q <= perm_fp({r_n, l_n});
      end else begin
        // Swap only: FP of this pass and IP of the next cancel out.
        l_q <= r_n; r_q <= l_n;
        {c_q, d_q} <= perm_pc1(pass_key(pass_q + 2'd1, tdes_q && dec_q, k1_q, k2_q, k3_q));
        pass_q <= pass_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_tdes_iter_core.sv
// -----------------------------------------------------------------------------
// tb_tdes_iter_core
// Directed bench for tdes_iter_core. Three instances (1, 4 and 16 rounds per
// clock) share the data inputs and have their own handshake signals. A vector
// table covers DES/3DES encrypt and decrypt with latency checks; hand-written
// sequences cover reset state, output backpressure with a same-edge accept,
// and reset in the middle of a 3DES operation.
// -----------------------------------------------------------------------------
module tb_tdes_iter_core;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              rst;
  logic [63:0]       din, key1, key2, key3;
  logic              decrypt, tdes;
  logic [2:0]        in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
  logic [2:0][63:0]  dout_s;
  logic [2:0][63:0]  last_dout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tdes_iter_core #(.ROUNDS_PER_CYCLE(1), .TDES_EN(1)) u_rpc1 (
    .clock(clock), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .din(din), .key1(key1), .key2(key2), .key3(key3), .decrypt(decrypt), .tdes(tdes),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .dout(dout_s[0]), .busy(busy_s[0]));

  tdes_iter_core #(.ROUNDS_PER_CYCLE(4), .TDES_EN(1)) u_rpc4 (
    .clock(clock), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .din(din), .key1(key1), .key2(key2), .key3(key3), .decrypt(decrypt), .tdes(tdes),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .dout(dout_s[1]), .busy(busy_s[1]));

  tdes_iter_core #(.ROUNDS_PER_CYCLE(16), .TDES_EN(1)) u_rpc16 (
    .clock(clock), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .din(din), .key1(key1), .key2(key2), .key3(key3), .decrypt(decrypt), .tdes(tdes),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .dout(dout_s[2]), .busy(busy_s[2]));

  typedef struct {
    int          sel;    // 0: 1 round/clk, 1: 4 rounds/clk, 2: 16 rounds/clk
    logic [63:0] din;
    logic [63:0] k1, k2, k3;
    logic        dec, tdes;
    logic        chain;  // use the previous result of this instance as din
    logic        chk;    // compare dout against exp
    logic [63:0] exp;
    int          lat;    // cycles from accept edge to first out_valid sample
  } vec_t;

  localparam logic [63:0] KA  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PA  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CA  = 64'h85E813540F0AB405;
  localparam logic [63:0] KB  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PB  = 64'h8787878787878787;
  localparam logic [63:0] R1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] R2  = 64'h23456789ABCDEF01;
  localparam logic [63:0] R3  = 64'h456789ABCDEF0123;
  localparam logic [63:0] PR  = 64'h6BC1BEE22E409F96;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called on a negedge; returns #1 after the accept edge.
  task automatic start_block(input int sel, input logic [63:0] d, k1, k2, k3,
                             input logic dec, td, input string name);
    int n = 0;
    while (!in_ready_s[sel] && n < 100) begin @(negedge clock); n++; end
    check({name, " in_ready"}, 64'(in_ready_s[sel]), 64'd1);
    din = d; key1 = k1; key2 = k2; key3 = k3; decrypt = dec; tdes = td;
    in_valid_s[sel] = 1'b1;
    @(posedge clock);
    #1 in_valid_s[sel] = 1'b0;
  endtask

  // Counts negedges until out_valid (bounded); ends on that negedge.
  task automatic wait_result(input int sel, input int lat, input logic chk,
                             input logic [63:0] exp, input string name);
    int n = 0;
    do begin @(negedge clock); n++; end while (!out_valid_s[sel] && n < 200);
    check({name, " latency"}, 64'(n), 64'(lat));
    if (chk) check({name, " dout"}, dout_s[sel], exp);
    last_dout[sel] = dout_s[sel];
  endtask

  task automatic take_result(input int sel, input string name);
    out_ready_s[sel] = 1'b1;
    @(posedge clock);
    #1 out_ready_s[sel] = 1'b0;
    @(negedge clock);
    check({name, " out_valid drop"}, 64'(out_valid_s[sel]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic        seen;

    //          sel din k1  k2  k3  dec   tdes  chain chk   exp lat
    vecs[0]  = '{0, PA, KA, KA, KA, 1'b0, 1'b0, 1'b0, 1'b1, CA, 17};
    vecs[1]  = '{0, CA, KA, KA, KA, 1'b1, 1'b0, 1'b0, 1'b1, PA, 17};
    vecs[2]  = '{0, PA, KA, KA, KA, 1'b0, 1'b1, 1'b0, 1'b1, CA, 49};
    vecs[3]  = '{0, CA, KA, KA, KA, 1'b1, 1'b1, 1'b0, 1'b1, PA, 49};
    vecs[4]  = '{0, PB, KB, KB, KB, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 17};
    vecs[5]  = '{0, 64'h0, KB, KB, KB, 1'b1, 1'b0, 1'b0, 1'b1, PB, 17};
    vecs[6]  = '{0, PR, R1, R2, R3, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 49};
    vecs[7]  = '{0, 64'h0, R1, R2, R3, 1'b1, 1'b1, 1'b1, 1'b1, PR, 49};
    vecs[8]  = '{1, PR, R1, R2, R3, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 13};
    vecs[9]  = '{1, 64'h0, R1, R2, R3, 1'b1, 1'b1, 1'b1, 1'b1, PR, 13};
    vecs[10] = '{2, PR, R1, R2, R3, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4};
    vecs[11] = '{2, 64'h0, R1, R2, R3, 1'b1, 1'b1, 1'b1, 1'b1, PR, 4};
    vecs[12] = '{1, PA, KA, KA, KA, 1'b0, 1'b0, 1'b0, 1'b1, CA, 5};
    vecs[13] = '{2, PA, KA, KA, KA, 1'b0, 1'b0, 1'b0, 1'b1, CA, 2};
    vecs[14] = '{2, CA, KA, KA, KA, 1'b1, 1'b1, 1'b0, 1'b1, PA, 4};

    rst = 1'b1; in_valid_s = '0; out_ready_s = '0; last_dout = '0;
    din = '0; key1 = '0; key2 = '0; key3 = '0; decrypt = 1'b0; tdes = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) rst = 1'b0;

    // Reset state
    check("reset out_valid", 64'(out_valid_s), 64'd0);
    check("reset busy",      64'(busy_s),      64'd0);
    check("reset in_ready",  64'(in_ready_s),  64'h7);
    check("reset dout0",     dout_s[0],        64'h0);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      d = vecs[i].chain ? last_dout[vecs[i].sel] : vecs[i].din;
      start_block(vecs[i].sel, d, vecs[i].k1, vecs[i].k2, vecs[i].k3,
                  vecs[i].dec, vecs[i].tdes, $sformatf("vec%0d", i));
      wait_result(vecs[i].sel, vecs[i].lat, vecs[i].chk, vecs[i].exp,
                  $sformatf("vec%0d", i));
      take_result(vecs[i].sel, $sformatf("vec%0d", i));
    end

    // Backpressure, then a new block accepted on the edge that takes the result
    start_block(0, PA, KA, KA, KA, 1'b0, 1'b0, "bp first");
    wait_result(0, 17, 1'b1, CA, "bp first");
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("bp hold dout", dout_s[0], CA);
      check("bp hold valid/ready/busy",
            64'({out_valid_s[0], in_ready_s[0], busy_s[0]}), 64'b101);
    end
    din = CA; key1 = KA; key2 = KA; key3 = KA; decrypt = 1'b1; tdes = 1'b0;
    out_ready_s[0] = 1'b1; in_valid_s[0] = 1'b1;
    #1 check("bp same-edge in_ready", 64'(in_ready_s[0]), 64'd1);
    @(posedge clock);
    #1 begin in_valid_s[0] = 1'b0; out_ready_s[0] = 1'b0; end
    @(negedge clock);
    check("bp after pulse valid/busy", 64'({out_valid_s[0], busy_s[0]}), 64'b01);
    // One negedge after the accept edge has already been consumed above.
    wait_result(0, 16, 1'b1, PA, "bp second");
    take_result(0, "bp second");

    // Reset during pass 2, round 7 of a 3DES block
    start_block(0, PA, KA, KA, KA, 1'b0, 1'b1, "mid rst");
    repeat (22) @(posedge clock);  // now in ROUND cycle 23: pass 2, round 7
    @(negedge clock) rst = 1'b1;
    @(negedge clock) rst = 1'b0;
    check("mid rst out_valid", 64'(out_valid_s[0]), 64'd0);
    check("mid rst dout",      dout_s[0],           64'h0);
    check("mid rst in_ready",  64'(in_ready_s[0]),  64'd1);
    check("mid rst busy",      64'(busy_s[0]),      64'd0);
    seen = 1'b0;
    repeat (60) begin @(negedge clock); seen |= out_valid_s[0]; end
    check("mid rst no result", 64'(seen), 64'd0);
    start_block(0, PA, KA, KA, KA, 1'b0, 1'b1, "post rst");
    wait_result(0, 49, 1'b1, CA, "post rst");
    take_result(0, "post rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tdes_iter_core.md
Name: tdes_iter_core

Overview:
Iterative DES/3DES block-cipher core with encrypt and decrypt modes, a keyed per-block mode select, and a configurable number of Feistel rounds per clock. It is the successor to the single-DES encrypt-only FSM core. It has valid/ready handshakes on both sides and sits between the key/plaintext front-end and the output buffer in the crypto datapath. It reuses the existing des_ip_stage, pc1_perm, pc2_perm, f_func and fp_perm blocks.

Parameters:
ROUNDS_PER_CYCLE, 1, Feistel rounds unrolled per clock. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
TDES_EN, 1, 1 builds the 3-pass EDE sequencer; 0 builds single DES only, and `tdes` is ignored.

Ports:
clock  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input block and controls valid
in_ready  out  1  core can accept a block this cycle
din  in  64  plaintext (encrypt) or ciphertext (decrypt)
key1  in  64  DES key 1, parity bits ignored
key2  in  64  DES key 2, used only for 3DES
key3  in  64  DES key 3, used only for 3DES
decrypt  in  1  0 = encrypt, 1 = decrypt
tdes  in  1  0 = single DES using key1, 1 = 3DES EDE
out_valid  out  1  dout holds a result
out_ready  in  1  consumer accepts dout
dout  out  64  result block
busy  out  1  high from accept until the result is taken

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: out_valid=0, dout=0, busy=0, FSM=IDLE, all internal L/R/C/D/key registers cleared. in_ready is 1 in the first cycle after reset.
- Reset asserted mid-operation aborts the block. The result is discarded and no out_valid is produced.
- Accept occurs when in_valid && in_ready at a clock edge. On accept the core registers:
  - L,R = IP(din);
  - C,D = PC1 of the pass-1 key;
  - decrypt, tdes and all three keys.
- Inputs are don't-care after accept.
- Passes P = 3 if (TDES_EN && tdes), else 1. Cycles per pass N = 16/ROUNDS_PER_CYCLE.
- Pass keys and directions:
  - Single DES: key1, direction = decrypt.
  - 3DES encrypt: E(key1), D(key2), E(key3).
  - 3DES decrypt: D(key3), E(key2), D(key1).
- FSM states: IDLE, ROUND, DONE.
  - IDLE→ROUND on accept.
  - ROUND lasts P*N cycles. The round counter runs 0..15 and advances by ROUNDS_PER_CYCLE each cycle; a pass counter runs 0..P-1.
  - ROUND→DONE after the last cycle of the last pass.
- Round step: L'=R; R'=L^f(R,K). Within one cycle, ROUNDS_PER_CYCLE steps are chained combinationally.
- Encrypt key schedule: before round r, rotate C and D left by 1 for r in {1,2,9,16}, else by 2. Then K=PC2(C,D).
- Decrypt key schedule:
  - Round 1 uses PC2(C0,D0) with no rotation.
  - Before round i (i≥2), rotate right by 1 for i in {2,9,16}, else by 2.
- Pass boundary:
  - Load L,R = {R16,L16}. This is the swap; FP followed by IP cancels.
  - Reload C,D from PC1 of the next pass key.
  - Reset the round counter to 0.
  - The boundary adds no extra cycle.
- DONE:
  - dout = FP({R16,L16}) is registered on the edge that enters DONE, and out_valid=1 from that edge.
  - Latency: out_valid rises exactly P*N+1 edges after the accept edge.
- Output hold: dout and out_valid hold stable until out_ready=1. On the edge where out_valid&&out_ready: out_valid→0 and DONE→IDLE, unless a new accept happens on the same edge (then DONE→ROUND).
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back throughput of one block per P*N+1 cycles.
- busy = (state!=IDLE).
- in_valid while not in_ready is ignored; nothing is queued.

Test Plan:
- Single DES encrypt, ROUNDS_PER_CYCLE=1: key1=133457799BBCDFF1, din=0123456789ABCDEF, decrypt=0, tdes=0 → dout=85E813540F0AB405; out_valid exactly 17 cycles after the accept edge.
- Single DES decrypt: same key, din=85E813540F0AB405, decrypt=1 → dout=0123456789ABCDEF.
- 3DES with key1=key2=key3=133457799BBCDFF1, din=0123456789ABCDEF, encrypt → dout=85E813540F0AB405 after 49 cycles.
- 3DES round trip with key1=0123456789ABCDEF, key2=23456789ABCDEF01, key3=456789ABCDEF0123, din=6BC1BEE22E409F96:
  - encrypt, then feed the result back with decrypt=1;
  - → dout=6BC1BEE22E409F96.
  - Run for ROUNDS_PER_CYCLE=1, 4 and 16; latency must be 49, 13 and 4 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → dout stable, in_ready=0, busy=1. Then pulse out_ready with in_valid=1 → the new block is accepted on the same edge and out_valid falls.
- Reset mid-op: assert rst for 1 cycle at round 7 of pass 2 → next cycle out_valid=0, dout=0, in_ready=1, busy=0, and no result appears. A subsequent block still returns the correct vector.
